// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_pkg
// Description : Shared types and constants for the I2S receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_pkg;

  typedef enum logic {
    I2S_MODE = 1'b0,
    LJ_MODE  = 1'b1
  } i2s_mode_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    RUN       = 2'd2
  } i2s_rx_state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // I2S marks the left channel with lrck low, left-justified with lrck high.
  function automatic logic map_channel(input logic lrck, input i2s_mode_t mode);
    if (mode == LJ_MODE) return lrck ? CH_LEFT : CH_RIGHT;
    return lrck ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_pin_sync_module.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pin_sync_module
// Description : Multi-stage synchroniser for the bck/lrck/dat pins with a
//               single-cycle rising-edge strobe for the synchronised bck.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_pin_sync_module #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bck_i,
  input  logic lrck_i,
  input  logic dat_i,
  output logic lrck_o,
  output logic dat_o,
  output logic bck_rise_o
);

  // Each stage holds {bck, lrck, dat}; index 0 is closest to the pins.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        bck_prev;

  // Shift the pin triplet through the synchroniser chain and keep the last bck.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      bck_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], {bck_i, lrck_i, dat_i}};
      bck_prev <= sync_q[SYNC_STAGES-1][2];
    end
  end

  assign bck_rise_o = sync_q[SYNC_STAGES-1][2] & ~bck_prev;
  assign lrck_o     = sync_q[SYNC_STAGES-1][1];
  assign dat_o      = sync_q[SYNC_STAGES-1][0];

endmodule
`default_nettype wire

// File: rtl/i2s_rx_stream_module.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_stream_module
// Description : Oversampling I2S / left-justified receiver delivering channel
//               words on a single-entry valid/ready stream with overrun and
//               frame-length error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_stream_module
  import i2s_rx_pkg::*;
#(
  parameter int DATA_RES    = 24,
  parameter int FRAME_RES   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic                bck_i,
  input  logic                lrck_i,
  input  logic                dat_i,
  output logic [DATA_RES-1:0] data_o,
  output logic                ch_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                ovr_o,
  output logic                ferr_o
);

  localparam int CNT_W = $clog2(FRAME_RES) + 1;

  logic                lrck_s;
  logic                dat_s;
  logic                bck_rise;

  i2s_rx_state_t       state;
  logic                prev_lrck;
  logic                have_prev;
  logic [CNT_W-1:0]    cnt;        // index of the bit sampled at the next bck rise
  logic [DATA_RES-1:0] shreg;
  i2s_mode_t           slot_mode;
  logic                commit;
  logic                commit_ch;
  logic [DATA_RES-1:0] commit_data;

  logic                lrck_edge;
  i2s_mode_t           eff_mode;
  logic [CNT_W-1:0]    idx_now;
  logic [CNT_W-1:0]    k;
  logic                k_ok;
  logic [DATA_RES-1:0] shreg_next;

  i2s_pin_sync_module #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bck_i      (bck_i),
    .lrck_i     (lrck_i),
    .dat_i      (dat_i),
    .lrck_o     (lrck_s),
    .dat_o      (dat_s),
    .bck_rise_o (bck_rise)
  );

  // An lrck edge only counts once a previous lrck sample exists, so a stale
  // reset value can never fake a slot boundary.
  assign lrck_edge = have_prev && (lrck_s != prev_lrck);

  // Work out where the current serial bit lands; a slot boundary restarts the
  // word at bit 0 using the freshly sampled mode.
  always_comb begin
    idx_now    = lrck_edge ? '0 : cnt;
    eff_mode   = lrck_edge ? i2s_mode_t'(mode_i) : slot_mode;
    shreg_next = lrck_edge ? '0 : shreg;
    if (eff_mode == LJ_MODE) begin
      k    = idx_now;
      k_ok = 32'(idx_now) < 32'(DATA_RES);
    end else begin
      k    = idx_now - CNT_W'(1);
      k_ok = (idx_now != '0) && (32'(k) < 32'(DATA_RES));
    end
    for (int b = 0; b < DATA_RES; b++) begin
      if (k_ok && (32'(k) == 32'(DATA_RES - 1 - b))) shreg_next[b] = dat_s;
    end
  end

  // Slot aligner: find the first lrck edge, then assemble and commit words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      prev_lrck   <= 1'b0;
      have_prev   <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      slot_mode   <= I2S_MODE;
      commit      <= 1'b0;
      commit_ch   <= 1'b0;
      commit_data <= '0;
      ferr_o      <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (bck_rise) prev_lrck <= lrck_s;
      if (!en_i) begin
        state     <= IDLE;
        have_prev <= 1'b0;
        cnt       <= '0;
        shreg     <= '0;
        ferr_o    <= 1'b0;
      end else begin
        if (bck_rise) have_prev <= 1'b1;
        case (state)
          IDLE: state <= WAIT_EDGE;
          WAIT_EDGE: begin
            if (bck_rise && lrck_edge) begin
              state     <= RUN;
              cnt       <= CNT_W'(1);
              shreg     <= shreg_next;
              slot_mode <= eff_mode;
            end
          end
          RUN: begin
            if (bck_rise) begin
              shreg <= shreg_next;
              if (lrck_edge) begin
                commit      <= 1'b1;
                commit_data <= shreg;
                commit_ch   <= map_channel(prev_lrck, slot_mode);
                cnt         <= CNT_W'(1);
                slot_mode   <= eff_mode;
              end else if (32'(cnt) >= 32'(FRAME_RES)) begin
                ferr_o <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Single-entry output register; a commit always wins over the held word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      ch_o    <= 1'b0;
      valid_o <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      ovr_o <= 1'b0;
      if (commit) begin
        data_o  <= commit_data;
        ch_o    <= commit_ch;
        valid_o <= 1'b1;
        ovr_o   <= valid_o && !ready_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_rx_stream_module.md
Name: i2s_rx_stream_module

Overview:
Next-generation I2S receiver. It oversamples the external bck/lrck/dat pins in a single system clock domain instead of clocking logic from bck. It supports I2S and left-justified framing, with runtime mode selection. Each received channel word is delivered on a valid/ready stream with a channel tag, plus overrun and frame-length error reporting. It sits between the pad ring and the audio DMA/FIFO.

Parameters:
DATA_RES, 24, bits per delivered sample (1..32)
FRAME_RES, 32, maximum bck periods per channel slot; bit counter width is $clog2(FRAME_RES)+1
SYNC_STAGES, 2, synchroniser flops per pin input (>=2)

Ports:
clk_i  input  1  system clock; must be >= 4x bck frequency
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  receiver enable; low = idle, discard in-flight word
mode_i  input  1  0 = I2S (1-bit delay, lrck low = left), 1 = left-justified (no delay, lrck high = left)
bck_i  input  1  serial bit clock pin (asynchronous)
lrck_i  input  1  word select pin (asynchronous)
dat_i  input  1  serial data pin (asynchronous)
data_o  output  DATA_RES  received sample, MSB-first reassembled, left-aligned
ch_o  output  1  0 = left, 1 = right
valid_o  output  1  data_o/ch_o valid
ready_i  input  1  consumer accepts when valid_o && ready_i
ovr_o  output  1  one-cycle pulse: a committed word overwrote an unaccepted one
ferr_o  output  1  sticky: slot longer than FRAME_RES; cleared by en_i low or reset

Behaviour:
- Reset (rst_ni low, async): data_o=0, ch_o=0, valid_o=0, ovr_o=0, ferr_o=0, all sync flops 0, aligner state IDLE.
- Pins pass through SYNC_STAGES flops. bck_rise = synced bck is 1 and its previous sample is 0. All serial sampling happens only on bck_rise cycles, using synced lrck/dat of that cycle.
- Aligner FSM:
  - IDLE -> WAIT_EDGE when en_i=1.
  - WAIT_EDGE -> RUN on the first bck_rise where lrck differs from the lrck captured at the prior bck_rise. Bits before this edge are discarded, so the first partial slot is never output.
  - RUN: at each bck_rise with an lrck change, commit the current word and restart the slot with bit_idx=0. Otherwise bit_idx increments.
  - Any state -> IDLE when en_i=0. The partial word is dropped, ferr_o cleared, valid_o unaffected.
- Capture: effective index k = bit_idx - 1 (I2S) or k = bit_idx (LJ). On bck_rise with 0<=k<DATA_RES, shift register bit [DATA_RES-1-k] <= dat. Bits with k>=DATA_RES are ignored. Shift register clears at slot start.
- Short slot (fewer than DATA_RES bits): missing LSBs are 0.
- Long slot: bit_idx saturates at FRAME_RES and sets ferr_o. The word is still committed at the next lrck change.
- Commit: ch = lrck level of the finished slot, mapped per mode_i. mode_i is sampled at slot start; a change mid-slot applies from the next slot.
- Output register, one entry:
  - On commit: data_o/ch_o load and valid_o=1 in the next clk cycle.
  - valid_o && ready_i with no commit: valid_o=0 next cycle.
  - Commit while valid_o=1 and ready_i=0: new word overwrites, valid_o stays 1, ovr_o=1 for one cycle.
  - Commit in the same cycle as a handshake: new word loads, valid_o stays 1, no ovr_o.
- Latency: valid_o rises SYNC_STAGES+2 clk cycles after the bck pin rising edge that carries the lrck change.
- data_o/ch_o hold stable while valid_o=1 && ready_i=0, except on overwrite.

Decomposition:
- Package i2s_rx_pkg:
  - typedef enum logic {I2S_MODE=0, LJ_MODE=1} i2s_mode_t
  - typedef enum logic [1:0] {IDLE, WAIT_EDGE, RUN} i2s_rx_state_t
  - localparam CH_LEFT=0, CH_RIGHT=1
- Sub-module i2s_pin_sync_module: parametrised SYNC_STAGES synchroniser for the 3 pins plus bck rising-edge detect. Reused by a future TX block.

Test Plan:
- I2S, DATA_RES=24, FRAME_RES=32, ready_i=1: frames L=0xA5A5A5, R=0x5A5A5A -> after the discarded first slot, data_o=0xA5A5A5 ch_o=0 then 0x5A5A5A ch_o=1, each valid_o 1 cycle, ovr_o=0.
- LJ mode, same words, lrck high = left -> identical output sequence; the same bitstream in I2S mode yields words shifted by one bit.
- Slot of 16 bck with DATA_RES=24, word 0x1234 -> data_o=0x123400. Slot of 40 bck -> ferr_o=1 and the word is still delivered.
- ready_i=0 across two commits -> second commit sets ovr_o=1 for 1 cycle, data_o=second word, valid_o held. Then ready_i=1 -> valid_o=0 next cycle.
- en_i dropped mid-slot then raised -> no output for the broken or first slots, ferr_o cleared, next full slot delivered correctly.
- rst_ni asserted mid-slot asynchronously (no clk edge) -> all outputs 0 immediately. After release, the first full slot following an lrck edge is output.
